// File: rtl/count_min_sec_if.sv
// Control and display bundle of the minutes/seconds counter.
// The timekeeper takes the slave view; whoever drives the controls and
// reads the digits takes the master view.
interface count_min_sec_if;
  logic       run;
  logic       inc_min;
  logic       inc_hour;
  logic       clr_sec;
  logic       up24;
  logic       tick;
  logic [3:0] display1;
  logic [3:0] display2;
  logic [3:0] sec_units;
  logic [3:0] sec_tens;

  modport slave (
    input  run, inc_min, inc_hour, clr_sec,
    output up24, tick, display1, display2, sec_units, sec_tens
  );

  modport master (
    output run, inc_min, inc_hour, clr_sec,
    input  up24, tick, display1, display2, sec_units, sec_tens
  );
endinterface

// File: rtl/count_min_sec.sv
// Upstream timekeeping stage. It divides ck down to a 1 s tick, keeps the
// BCD seconds and minutes, and pulses up24 to advance the hours counter.
// The user controls (run, inc_min, inc_hour, clr_sec) act on the edge
// where they are sampled high.
module count_min_sec #(
  parameter int TICK_DIV = 100000000
) (
  input logic           ck,
  input logic           rst,
  count_min_sec_if.slave bus
);

  localparam int             PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre, pre_nxt;
  logic [3:0]    su, st, mu, mt;
  logic [3:0]    su_nxt, st_nxt, mu_nxt, mt_nxt;
  logic          tick_en, sec_carry, min_adv, min_wrap, min_carry;
  logic          up24_q, tick_q;

  // Next state for the prescaler and both BCD digit pairs.
  // clr_sec beats a coincident tick, and a coincident inc_min absorbs a
  // seconds carry, so minutes advance by one and never raise min_carry.
  // The >= compares keep every digit inside its legal range.
  always_comb begin
    pre_nxt   = pre;
    su_nxt    = su;
    st_nxt    = st;
    mu_nxt    = mu;
    mt_nxt    = mt;
    sec_carry = 1'b0;
    tick_en   = bus.run && (pre >= PRE_MAX) && !bus.clr_sec;

    if (bus.clr_sec)
      pre_nxt = '0;
    else if (bus.run)
      pre_nxt = (pre >= PRE_MAX) ? '0 : pre + PW'(1);

    if (bus.clr_sec) begin
      su_nxt = 4'd0;
      st_nxt = 4'd0;
    end else if (tick_en) begin
      if (su >= 4'd9) begin
        su_nxt = 4'd0;
        if (st >= 4'd5) begin
          st_nxt    = 4'd0;
          sec_carry = 1'b1;
        end else begin
          st_nxt = st + 4'd1;
        end
      end else begin
        su_nxt = su + 4'd1;
      end
    end

    min_adv   = sec_carry || bus.inc_min;
    min_wrap  = (mu >= 4'd9) && (mt >= 4'd5);
    min_carry = sec_carry && !bus.inc_min && min_wrap;

    if (min_adv) begin
      if (mu >= 4'd9) begin
        mu_nxt = 4'd0;
        mt_nxt = (mt >= 4'd5) ? 4'd0 : mt + 4'd1;
      end else begin
        mu_nxt = mu + 4'd1;
      end
    end
  end

  // State register; rst overrides every control, including a live pulse.
  always_ff @(posedge ck) begin
    if (rst) begin
      pre    <= '0;
      su     <= 4'd0;
      st     <= 4'd0;
      mu     <= 4'd0;
      mt     <= 4'd0;
      up24_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pre    <= pre_nxt;
      su     <= su_nxt;
      st     <= st_nxt;
      mu     <= mu_nxt;
      mt     <= mt_nxt;
      up24_q <= min_carry || bus.inc_hour;
      tick_q <= tick_en;
    end
  end

  assign bus.up24      = up24_q;
  assign bus.tick      = tick_q;
  assign bus.display1  = mu;
  assign bus.display2  = mt;
  assign bus.sec_units = su;
  assign bus.sec_tens  = st;

endmodule
